// File: rtl/rv_lsu.sv
// rv_lsu: RV64 load/store unit driving a 64-bit doubleword-addressed memory; sub-doubleword stores use read-modify-write.
// Latency: load 2 cycles, SD 1, SB/SH/SW 3, illegal/misaligned 0 (response on the cycle after accept).
// Backpressure: req_ready only in IDLE, one request in flight. Optional define RV_LSU_MISALIGN_CHECK_EN faults misaligned accesses.
module rv_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [63:0] mem_wr_data,
    input  logic [63:0] mem_rd_data
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;
    logic        we_q;
    logic [63:0] wdata_q;

    logic        req_illegal;
    logic        req_misal;
    logic        req_err;
    logic [2:0]  align_mask;
    logic [2:0]  req_off;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^req_addr[63:35];

    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        align_mask  = 3'b111;
        case (req_funct3[1:0])
            2'b00: align_mask = 3'b111;
            2'b01: align_mask = 3'b110;
            2'b10: align_mask = 3'b100;
            2'b11: align_mask = 3'b000;
            default: align_mask = 3'b111;
        endcase
        req_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        req_misal   = |(req_addr[2:0] & ~align_mask);
        // Low bits below the access size are dropped, so offsets are always size-aligned.
        req_off     = req_addr[2:0] & align_mask;
`ifdef RV_LSU_MISALIGN_CHECK_EN
        req_err     = req_illegal || req_misal;
`else
        req_err     = req_illegal;
`endif
    end

    function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{56{sh[7]}},  sh[7:0]};
            3'b001:  load_extend = {{48{sh[15]}}, sh[15:0]};
            3'b010:  load_extend = {{32{sh[31]}}, sh[31:0]};
            3'b011:  load_extend = sh;
            3'b100:  load_extend = {56'd0, sh[7:0]};
            3'b101:  load_extend = {48'd0, sh[15:0]};
            3'b110:  load_extend = {32'd0, sh[31:0]};
            default: load_extend = 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] old,
                                                input logic [63:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0] base;
        logic [63:0] mask;
        case (f3[1:0])
            2'b00:   base = 64'h0000_0000_0000_00ff;
            2'b01:   base = 64'h0000_0000_0000_ffff;
            2'b10:   base = 64'h0000_0000_ffff_ffff;
            default: base = 64'hffff_ffff_ffff_ffff;
        endcase
        mask        = base << {off, 3'b000};
        store_merge = (old & ~mask) | ((wd << {off, 3'b000}) & mask);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            f3_q        <= 3'd0;
            off_q       <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= 64'd0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 64'd0;
            resp_err    <= 1'b0;
            mem_addr    <= 32'd0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 64'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q     <= req_funct3;
                        off_q    <= req_off;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        mem_addr <= req_addr[34:3];
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && (req_funct3[1:0] == 2'b11)) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= req_wdata;
                            state       <= WR;
                        end else begin
                            mem_rd_en <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                RD: state <= RWAIT;
                RWAIT: begin
                    // Memory data is valid here; stores merge and write back, loads respond directly.
                    if (we_q) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= store_merge(mem_rd_data, wdata_q, f3_q, off_q);
                        state       <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extend(mem_rd_data, f3_q, off_q);
                        state      <= IDLE;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
